mem_stage_access: RTL
=====================

// Module: mem_stage_access
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register. It decodes the registered
//  control (WB, we) and drives a req/gnt/rvalid data-memory bus, holding the
//  address and data stable until the transaction completes. It stalls the
//  pipeline while an access is outstanding and registers the MEM/WB stage
//  (control, load data, ALU result, destination register, error flags).
// PARAMETERS
//  DATA_W    32   data/address width
//  TIMEOUT   255  max cycles in REQ+WAIT_RSP before bus error (1..255)
// PORTS
//  clk              in   1       rising-edge clock
//  reset_n          in   1       asynchronous, active-low reset
//  WB_in            in   2       {RegWrite, MemtoReg} from EX/MEM; MemtoReg=1 marks a load
//  we_in            in   1       store enable from EX/MEM
//  ALUResult_in     in   DATA_W  effective address / ALU result
//  d_in             in   DATA_W  store data
//  rdAddr_in        in   5       destination register
//  dmem_req         out  1       bus request (registered)
//  dmem_we          out  1       1=write, 0=read; valid while dmem_req
//  dmem_addr        out  DATA_W  word address, stable while dmem_req
//  dmem_wdata       out  DATA_W  write data, stable while dmem_req
//  dmem_gnt         in   1       request accepted this cycle
//  dmem_rvalid      in   1       read data valid
//  dmem_rdata       in   DATA_W  read data
//  mem_stall        out  1       combinational; freeze PC/IF/ID/EX/EX-MEM
//  WB_out_MEM_WB    out  2       WB control to write-back stage
//  ReadData_wb      out  DATA_W  load data
//  ALUResult_wb     out  DATA_W  pass-through ALU result
//  rdAddr_wb        out  5       destination register
//  align_err_wb     out  1       misaligned access retired this cycle
//  bus_err_wb       out  1       timed-out access retired this cycle
// BEHAVIOUR
//  - access = we_in | WB_in[0]; aligned = ALUResult_in[1:0]==0.
//  - On reset (async assert): state=IDLE, dmem_req=0; all registered outputs 0.
//    A transaction in flight is abandoned; dmem_req drops immediately.
//  - FSM IDLE/REQ/WAIT_RSP/DONE:
//    IDLE:    access&aligned -> REQ, latch we/addr/wdata. Otherwise stay.
//    REQ:     dmem_req=1. gnt & store -> DONE; gnt & load -> WAIT_RSP.
//    WAIT_RSP: rvalid -> capture rdata, go DONE. rvalid in the gnt cycle is ignored.
//    DONE:    1 cycle, no stall, -> IDLE.
//  - mem_stall = (IDLE & access & aligned) | REQ | WAIT_RSP.
//  - MEM/WB register, every clk edge:
//    * mem_stall=1: WB_out_MEM_WB<=0 and both error flags <=0 (bubble); other fields hold.
//    * otherwise: load WB_in, ALUResult_in, rdAddr_in. ReadData_wb<=captured rdata
//      (DONE) or 0.
//  - Misaligned access: no bus cycle, no stall. Retires with WB_out_MEM_WB[1] forced 0,
//    align_err_wb=1, ReadData_wb=0.
//  - Watchdog: 8-bit counter cleared on entering REQ, counts in REQ/WAIT_RSP.
//    Reaching TIMEOUT -> DONE with data 0. The instruction retires with RegWrite
//    forced 0 and bus_err_wb=1.
//  - gnt outside REQ and rvalid outside WAIT_RSP are ignored.
//  - Minimum stall: store 2 cycles (IDLE, REQ with gnt); load 3 (gnt, then rvalid next).
// TESTING
//  1 ALU op WB_in=2'b10, ALUResult=32'h1234, rd=5 -> no stall, no dmem_req; next edge
//    WB_out=2'b10, ALUResult_wb=32'h1234, rdAddr_wb=5.
//  2 store addr 32'h40 data 32'hDEADBEEF, gnt immediate -> stall 2 cycles; dmem_req=1
//    for 1 cycle with addr/data stable; retire WB_out=0.
//  3 load addr 32'h80, gnt after 2 cycles, rvalid 3 cycles later with 32'hCAFEF00D ->
//    stall held until DONE; ReadData_wb=32'hCAFEF00D, WB_out=2'b11.
//  4 load addr 32'h82 -> no dmem_req, no stall; align_err_wb=1, WB_out=2'b01.
//  5 TIMEOUT=4, load with gnt but no rvalid -> DONE after 4 counted cycles;
//    bus_err_wb=1, ReadData_wb=0, RegWrite=0.
//  6 reset_n low while in WAIT_RSP -> dmem_req, mem_stall and all outputs 0 at once;
//    a late rvalid after release is ignored.

Source files
------------

// File: rtl/mem_stage_access.sv
// MEM stage: drives a req/gnt/rvalid data bus from EX/MEM control and registers MEM/WB.
// Stalls the pipeline while an aligned access is outstanding; a watchdog bounds each access.
module mem_stage_access #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        WB_in,
  input  logic              we_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic [4:0]        rdAddr_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic [1:0]        WB_out_MEM_WB,
  output logic [DATA_W-1:0] ReadData_wb,
  output logic [DATA_W-1:0] ALUResult_wb,
  output logic [4:0]        rdAddr_wb,
  output logic              align_err_wb,
  output logic              bus_err_wb
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        wd_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              bus_err_q;

  logic access;
  logic aligned;
  logic misalign;
  logic wd_expire;
  logic in_done;

  assign access    = we_in | WB_in[0];
  assign aligned   = (ALUResult_in[1:0] == 2'b00);
  assign misalign  = (state == IDLE) & access & ~aligned;
  assign wd_expire = (wd_cnt == WD_LAST);
  assign in_done   = (state == DONE);

  // Gated by reset so the stall drops the instant reset is asserted.
  assign mem_stall = reset_n & (((state == IDLE) & access & aligned) |
                                (state == REQ) | (state == WAIT_RSP));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wd_cnt     <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access && aligned) begin
            state      <= REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= we_in;
            dmem_addr  <= ALUResult_in;
            dmem_wdata <= d_in;
            wd_cnt     <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
          end
        end
        REQ: begin
          wd_cnt <= wd_cnt + 8'd1;
          if (dmem_gnt && dmem_we) begin
            state    <= DONE;
            dmem_req <= 1'b0;
          end else if (wd_expire) begin
            state     <= DONE;
            dmem_req  <= 1'b0;
            bus_err_q <= 1'b1;
          end else if (dmem_gnt) begin
            state    <= WAIT_RSP;
            dmem_req <= 1'b0;
          end
        end
        WAIT_RSP: begin
          wd_cnt <= wd_cnt + 8'd1;
          if (dmem_rvalid) begin
            state   <= DONE;
            rdata_q <= dmem_rdata;
          end else if (wd_expire) begin
            state     <= DONE;
            bus_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      WB_out_MEM_WB <= '0;
      ReadData_wb   <= '0;
      ALUResult_wb  <= '0;
      rdAddr_wb     <= '0;
      align_err_wb  <= 1'b0;
      bus_err_wb    <= 1'b0;
    end else if (mem_stall) begin
      WB_out_MEM_WB <= '0;
      align_err_wb  <= 1'b0;
      bus_err_wb    <= 1'b0;
    end else begin
      WB_out_MEM_WB <= {WB_in[1] & ~misalign & ~(in_done & bus_err_q), WB_in[0]};
      ReadData_wb   <= in_done ? rdata_q : '0;
      ALUResult_wb  <= ALUResult_in;
      rdAddr_wb     <= rdAddr_in;
      align_err_wb  <= misalign;
      bus_err_wb    <= in_done & bus_err_q;
    end
  end

endmodule
